// File: rtl/raster_pkg.sv
// Shared types and constants for the raster scanner: FSM state encoding,
// default screen geometry and the battle sprite size.
package raster_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SCAN = 2'd1,
      DONE = 2'd2
   } state_e;

   localparam int DefScreenW       = 160;
   localparam int DefScreenH       = 120;
   localparam int BattleSpriteSize = 40;

endpackage

// File: rtl/scan_counter.sv
// Clearable up-counter that wraps to zero after reaching limit-1; terminal
// flags the last count so the parent can chain counters.
module scan_counter #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         resetn,
   input  logic         clear,
   input  logic         enable,
   input  logic [W-1:0] limit,
   output logic [W-1:0] count,
   output logic         terminal
);

   logic [W-1:0] count_q, count_d;

   assign terminal = (count_q == limit - W'(1));
   assign count    = count_q;

   always_comb begin
      count_d = count_q;
      if (clear) begin
         count_d = '0;
      end else if (enable) begin
         count_d = terminal ? '0 : count_q + W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

endmodule

// File: rtl/raster_scanner.sv
// Walks a rectangular region in raster order, one pixel per cycle, emitting
// screen coordinates, a plot strobe and a linear sprite address.
// Optional screen clipping of plot is enabled with RASTER_SCANNER_CLIP_EN.
module raster_scanner
   import raster_pkg::*;
#(
   parameter int X_W      = 8,
   parameter int Y_W      = 7,
   parameter int SCREEN_W = DefScreenW,
   parameter int SCREEN_H = DefScreenH,
   parameter int ADDR_W   = 15
) (
   input  logic              clk,
   input  logic              resetn,
   input  logic              start,
   input  logic [X_W-1:0]    x_init,
   input  logic [Y_W-1:0]    y_init,
   input  logic [X_W-1:0]    width,
   input  logic [Y_W-1:0]    height,
   input  logic              hold,
   output logic [X_W-1:0]    x,
   output logic [Y_W-1:0]    y,
   output logic [ADDR_W-1:0] addr,
   output logic              plot,
   output logic              busy,
   output logic              done
);

   state_e            state_q, state_d;
   logic [X_W-1:0]    x0_q, x0_d, w_q, w_d;
   logic [Y_W-1:0]    y0_q, y0_d, h_q, h_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic              done_q, done_d;

   logic              cnt_clear, col_en, row_en;
   logic [X_W-1:0]    col;
   logic [Y_W-1:0]    row;
   logic              col_term, row_term;
   logic              on_screen;

   scan_counter #(.W(X_W)) u_col (
      .clk      (clk),
      .resetn   (resetn),
      .clear    (cnt_clear),
      .enable   (col_en),
      .limit    (w_q),
      .count    (col),
      .terminal (col_term)
   );

   scan_counter #(.W(Y_W)) u_row (
      .clk      (clk),
      .resetn   (resetn),
      .clear    (cnt_clear),
      .enable   (row_en),
      .limit    (h_q),
      .count    (row),
      .terminal (row_term)
   );

`ifdef RASTER_SCANNER_CLIP_EN
   logic [X_W:0] x_full;
   logic [Y_W:0] y_full;
   // One bit wider than the outputs so off-screen pixels never wrap back on.
   assign x_full    = {1'b0, x0_q} + {1'b0, col};
   assign y_full    = {1'b0, y0_q} + {1'b0, row};
   assign on_screen = (x_full < (X_W+1)'(SCREEN_W)) && (y_full < (Y_W+1)'(SCREEN_H));
`else
   logic unused_screen;
   assign unused_screen = ^{SCREEN_W[0], SCREEN_H[0]};
   assign on_screen     = 1'b1;
`endif

   assign x    = x0_q + col;
   assign y    = y0_q + row;
   assign addr = addr_q;
   assign busy = (state_q == SCAN);
   assign plot = busy && !hold && on_screen;
   assign done = done_q;

   always_comb begin
      state_d   = state_q;
      x0_d      = x0_q;
      y0_d      = y0_q;
      w_d       = w_q;
      h_d       = h_q;
      addr_d    = addr_q;
      done_d    = 1'b0;
      cnt_clear = 1'b0;
      col_en    = 1'b0;
      row_en    = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (start) begin
               x0_d      = x_init;
               y0_d      = y_init;
               w_d       = width;
               h_d       = height;
               addr_d    = '0;
               cnt_clear = 1'b1;
               state_d   = (width == '0 || height == '0) ? DONE : SCAN;
            end
         end
         SCAN: begin
            if (!hold) begin
               col_en = 1'b1;
               row_en = col_term;
               if (col_term && row_term) begin
                  state_d = DONE;
               end else begin
                  addr_d = addr_q + ADDR_W'(1);
               end
            end
         end
         DONE: begin
            // Stay one extra cycle so the registered done pulse is seen while
            // start is still ignored.
            if (done_q) begin
               state_d = IDLE;
            end else begin
               done_d = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         state_q <= IDLE;
         x0_q    <= '0;
         y0_q    <= '0;
         w_q     <= '0;
         h_q     <= '0;
         addr_q  <= '0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         x0_q    <= x0_d;
         y0_q    <= y0_d;
         w_q     <= w_d;
         h_q     <= h_d;
         addr_q  <= addr_d;
         done_q  <= done_d;
      end
   end

endmodule

// File: tb/tb_raster_scanner.sv
// Directed self-checking bench for raster_scanner; expectations follow the
// RASTER_SCANNER_CLIP_EN setting where clipping changes the plot count.
module tb_raster_scanner;

   logic        clk = 1'b0;
   logic        resetn, start, hold;
   logic [7:0]  x_init, width, x;
   logic [6:0]  y_init, height, y;
   logic [14:0] addr;
   logic        plot, busy, done;

   int n_assert = 0;
   int n_fail   = 0;

   raster_scanner u_dut (
      .clk    (clk),
      .resetn (resetn),
      .start  (start),
      .x_init (x_init),
      .y_init (y_init),
      .width  (width),
      .height (height),
      .hold   (hold),
      .x      (x),
      .y      (y),
      .addr   (addr),
      .plot   (plot),
      .busy   (busy),
      .done   (done)
   );

   always #5 clk = ~clk;

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic smp();
      @(negedge clk);
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic start_scan(input int xi, input int yi, input int w, input int h);
      cyc();
      start  = 1'b1;
      x_init = 8'(xi);
      y_init = 7'(yi);
      width  = 8'(w);
      height = 7'(h);
   endtask

   initial begin
      int ex[6] = '{10, 11, 12, 10, 11, 12};
      int ey[6] = '{20, 20, 20, 21, 21, 21};
      int pi, plots, dones, done_c, lx, ly, la, mism, a151;

      resetn = 1'b0;
      start  = 1'b0;
      hold   = 1'b0;
      x_init = '0;
      y_init = '0;
      width  = '0;
      height = '0;
      cyc();
      cyc();
      smp();
      chk("rst_x", x, 0);
      chk("rst_y", y, 0);
      chk("rst_addr", addr, 0);
      chk("rst_plot", plot, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      cyc();
      resetn = 1'b1;

      // Basic 3x2 scan; origin inputs change after acceptance.
      start_scan(10, 20, 3, 2);
      for (int c = 1; c <= 9; c++) begin
         cyc();
         start  = 1'b0;
         x_init = 8'd99;
         smp();
         chk("t1_plot", plot, (c <= 6));
         chk("t1_busy", busy, (c <= 6));
         chk("t1_done", done, (c == 8));
         if (c <= 6) begin
            chk("t1_x", x, ex[c-1]);
            chk("t1_y", y, ey[c-1]);
            chk("t1_addr", addr, c - 1);
         end
      end

      // Same scan with hold on scan cycles 2 and 4.
      start_scan(10, 20, 3, 2);
      pi = 0;
      for (int c = 1; c <= 11; c++) begin
         cyc();
         start = 1'b0;
         hold  = (c == 2 || c == 4);
         smp();
         chk("t2_done", done, (c == 10));
         chk("t2_busy", busy, (c <= 8));
         if (c <= 8) begin
            chk("t2_plot", plot, !hold);
            chk("t2_x", x, ex[pi]);
            chk("t2_y", y, ey[pi]);
            chk("t2_addr", addr, pi);
            if (!hold) pi++;
         end
      end
      hold = 1'b0;
      chk("t2_pixels", pi, 6);

      // Zero-width region; start during the done pulse must not re-trigger.
      start_scan(0, 0, 0, 5);
      for (int c = 1; c <= 5; c++) begin
         cyc();
         start = (c == 2);
         smp();
         chk("t3_plot", plot, 0);
         chk("t3_busy", busy, 0);
         chk("t3_done", done, (c == 2));
      end

      // Full screen with a stray start mid-scan.
      start_scan(0, 0, 160, 120);
      plots = 0; dones = 0; done_c = 0; lx = -1; ly = -1; la = -1; mism = 0;
      for (int c = 1; c <= 19210; c++) begin
         cyc();
         start = (c == 5000);
         smp();
         if (plot) begin
            if (addr !== 15'(plots) || x !== 8'(plots % 160) || y !== 7'(plots / 160)) mism++;
            lx = int'(x); ly = int'(y); la = int'(addr);
            plots++;
         end
         if (done) begin
            dones++;
            done_c = c;
         end
      end
      chk("fs_plots", plots, 19200);
      chk("fs_order", mism, 0);
      chk("fs_last_x", lx, 159);
      chk("fs_last_y", ly, 119);
      chk("fs_last_addr", la, 19199);
      chk("fs_dones", dones, 1);
      chk("fs_done_cycle", done_c, 19202);

      // Reset during row 1 of a battle-sized scan, then restart.
      start_scan(90, 30, raster_pkg::BattleSpriteSize, raster_pkg::BattleSpriteSize);
      for (int c = 1; c <= 45; c++) begin
         cyc();
         start = 1'b0;
         smp();
      end
      chk("rs_mid_x", x, 94);
      chk("rs_mid_y", y, 31);
      chk("rs_mid_addr", addr, 44);
      cyc();
      resetn = 1'b0;
      cyc();
      resetn = 1'b1;
      smp();
      chk("rs_x", x, 0);
      chk("rs_y", y, 0);
      chk("rs_addr", addr, 0);
      chk("rs_plot", plot, 0);
      chk("rs_busy", busy, 0);
      chk("rs_done", done, 0);
      start_scan(10, 20, 3, 2);
      for (int c = 1; c <= 9; c++) begin
         cyc();
         start = 1'b0;
         smp();
         if (c == 1) begin
            chk("rs2_plot", plot, 1);
            chk("rs2_x", x, 10);
            chk("rs2_y", y, 20);
            chk("rs2_addr", addr, 0);
         end
         chk("rs2_done", done, (c == 8));
      end

      // 20x20 region straddling the bottom-right screen corner.
      start_scan(150, 110, 20, 20);
      plots = 0; done_c = 0; a151 = -1;
      for (int c = 1; c <= 405; c++) begin
         cyc();
         start = 1'b0;
         smp();
         if (plot) begin
            plots++;
            if (x == 8'd151 && y == 7'd111) a151 = int'(addr);
         end
         if (done) done_c = c;
      end
`ifdef RASTER_SCANNER_CLIP_EN
      chk("cl_plots", plots, 100);
`else
      chk("cl_plots", plots, 400);
`endif
      chk("cl_addr_151_111", a151, 21);
      chk("cl_done_cycle", done_c, 402);

      // x origin near 255 so the coordinate wraps modulo 256.
      start_scan(250, 0, 10, 1);
      plots = 0;
      for (int c = 1; c <= 12; c++) begin
         cyc();
         start = 1'b0;
         smp();
         if (plot) plots++;
         if (c == 10) chk("wr_x", x, 3);
         chk("wr_done", done, (c == 12));
      end
`ifdef RASTER_SCANNER_CLIP_EN
      chk("wr_plots", plots, 0);
`else
      chk("wr_plots", plots, 10);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
